// File: rtl/slave_ufi_read_merge.sv
// ---------------------------------------------------------------------------
// slave_ufi_read_merge
//
// Slave-side UFI read-return path. A master read request is decoded by the
// top four address bits into a one-hot read enable for one of up to
// pUfiAllocationNum sub-slaves. The block then waits (bounded by
// pTimeoutCycles) for that sub-slave's read-valid and hands its data back to
// the master as a single-cycle valid pulse. Out-of-range selects and timeouts
// are answered with an error pulse and zero data.
//
// Ports:
//   iCLK        system clock
//   iRST        asynchronous active-low reset
//   iSUfiRAdrs  read address from master (bits [MSB -: 4] select sub-slave)
//   iSUfiREd    read request strobe from master (1-cycle pulse)
//   oSUfiRAdrs  registered read address to sub-slaves
//   oSUfiREd    one-hot read enable to sub-slaves (1-cycle pulse)
//   iSUfiRd     concatenated sub-slave read data, slave n at [n*W +: W]
//   iSUfiRVd    per-sub-slave read-data valid
//   oSUfiRd     read data to master (valid while oSUfiRVd is high, else 0)
//   oSUfiRVd    read data valid to master (1-cycle pulse)
//   oSUfiRErr   error flag, qualified by oSUfiRVd
//   oSUfiBusy   high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module slave_ufi_read_merge #(
  parameter int pUfiBusWidth      = 32,
  parameter int pUsiBusWidth      = 32,
  parameter int pUfiAllocationNum = 9,
  parameter int pTimeoutCycles    = 15
) (
  input  logic                                      iCLK,
  input  logic                                      iRST,
  input  logic [pUsiBusWidth-1:0]                   iSUfiRAdrs,
  input  logic                                      iSUfiREd,
  output logic [pUsiBusWidth-1:0]                   oSUfiRAdrs,
  output logic [pUfiAllocationNum-1:0]              oSUfiREd,
  input  logic [pUfiAllocationNum*pUfiBusWidth-1:0] iSUfiRd,
  input  logic [pUfiAllocationNum-1:0]              iSUfiRVd,
  output logic [pUfiBusWidth-1:0]                   oSUfiRd,
  output logic                                      oSUfiRVd,
  output logic                                      oSUfiRErr,
  output logic                                      oSUfiBusy
);

  localparam int CntWidth = $clog2(pTimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(pTimeoutCycles);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [CntWidth-1:0]            cnt_q, cnt_d;
  logic [3:0]                     idx_q, idx_d;
  logic [pUsiBusWidth-1:0]        addr_q, addr_d;
  logic [pUfiAllocationNum-1:0]   ren_q, ren_d;
  logic [pUfiBusWidth-1:0]        rd_q, rd_d;
  logic                           rvd_q, rvd_d;
  logic                           rerr_q, rerr_d;

  logic [3:0]                     req_idx;
  logic                           req_in_range;
  logic [pUfiAllocationNum-1:0]   req_onehot;
  logic [pUfiAllocationNum-1:0]   sel_onehot;
  logic                           sel_vd;
  logic [pUfiBusWidth-1:0]        sel_data;
  logic [CntWidth-1:0]            cnt_inc;

  assign req_idx      = iSUfiRAdrs[pUsiBusWidth-1 -: 4];
  // Zero-extended compare so pUfiAllocationNum = 16 does not overflow 4 bits.
  assign req_in_range = ({1'b0, req_idx} < 5'(pUfiAllocationNum));

  // One-hot decodes: the incoming request (drives the enable) and the latched
  // index (selects which valid/data lane is listened to while waiting).
  // Decoding the latched index to a mask keeps every lane access in range even
  // when fewer than 16 sub-slaves exist.
  for (genvar gi = 0; gi < pUfiAllocationNum; gi++) begin : g_decode
    assign req_onehot[gi] = (req_idx == 4'(gi));
    assign sel_onehot[gi] = (idx_q == 4'(gi));
  end

  // Only the selected lane can contribute; valids of other sub-slaves are
  // masked off regardless of state.
  assign sel_vd = |(iSUfiRVd & sel_onehot);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < pUfiAllocationNum; i++) begin
      if (sel_onehot[i]) begin
        sel_data = sel_data | iSUfiRd[i*pUfiBusWidth +: pUfiBusWidth];
      end
    end
  end

  assign cnt_inc = cnt_q + CntWidth'(1);

  // Next-state and registered-output logic. Outputs are computed one cycle
  // ahead so that they appear registered in the state they belong to:
  // the enable is loaded on the IDLE->ISSUE edge, the response on the edge
  // into RESP, and everything falls back to zero by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    ren_d   = '0;
    rd_d    = '0;
    rvd_d   = 1'b0;
    rerr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (iSUfiREd) begin
          addr_d = iSUfiRAdrs;
          idx_d  = req_idx;
          if (req_in_range) begin
            ren_d   = req_onehot;
            state_d = ISSUE;
          end else begin
            // No such sub-slave: answer immediately with an error.
            rvd_d   = 1'b1;
            rerr_d  = 1'b1;
            state_d = RESP;
          end
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // A valid on the last permitted cycle wins over the timeout.
        if (sel_vd) begin
          rd_d    = sel_data;
          rvd_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_inc == CntLast) begin
          rvd_d   = 1'b1;
          rerr_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      ren_q   <= '0;
      rd_q    <= '0;
      rvd_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      rd_q    <= rd_d;
      rvd_q   <= rvd_d;
      rerr_q  <= rerr_d;
    end
  end

  assign oSUfiRAdrs = addr_q;
  assign oSUfiREd   = ren_q;
  assign oSUfiRd    = rd_q;
  assign oSUfiRVd   = rvd_q;
  assign oSUfiRErr  = rerr_q;
  assign oSUfiBusy  = (state_q != IDLE);

endmodule

// File: tb/tb_slave_ufi_read_merge.sv
// ---------------------------------------------------------------------------
// Testbench for slave_ufi_read_merge. Requests push their expected response
// (data, error, response cycle) to a scoreboard queue; a monitor pops and
// compares on every response pulse. A responder model plays the sub-slaves,
// answering each enable after a configured delay.
// ---------------------------------------------------------------------------
module tb_slave_ufi_read_merge;

  localparam int W  = 32;
  localparam int A  = 32;
  localparam int N  = 9;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [A-1:0]     req_adrs = '0;
  logic             req_ed = 1'b0;
  logic [A-1:0]     sub_adrs;
  logic [N-1:0]     sub_ren;
  logic [N*W-1:0]   sub_rd;
  logic [N-1:0]     sub_rvd;
  logic [W-1:0]     rsp_rd;
  logic             rsp_rvd;
  logic             rsp_err;
  logic             busy;

  slave_ufi_read_merge #(
    .pUfiBusWidth(W),
    .pUsiBusWidth(A),
    .pUfiAllocationNum(N),
    .pTimeoutCycles(TO)
  ) dut (
    .iCLK(clk),
    .iRST(rst_n),
    .iSUfiRAdrs(req_adrs),
    .iSUfiREd(req_ed),
    .oSUfiRAdrs(sub_adrs),
    .oSUfiREd(sub_ren),
    .iSUfiRd(sub_rd),
    .iSUfiRVd(sub_rvd),
    .oSUfiRd(rsp_rd),
    .oSUfiRVd(rsp_rvd),
    .oSUfiRErr(rsp_err),
    .oSUfiBusy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           at;
  } exp_t;

  typedef struct {
    int           k;
    logic [W-1:0] data;
  } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];

  int errors = 0;
  int checks = 0;
  int rsp_count = 0;

  // Sub-slave model: one target lane driven by the responder, plus "noise"
  // lanes that hold valid high with all-ones data.
  logic [N-1:0] tgt_vd = '0;
  logic [N-1:0] noise_vd = '0;
  logic [W-1:0] tgt_data = '0;

  assign sub_rvd = tgt_vd | noise_vd;

  always_comb begin
    sub_rd = '0;
    for (int n = 0; n < N; n++) begin
      if (tgt_vd[n])        sub_rd[n*W +: W] = tgt_data;
      else if (noise_vd[n]) sub_rd[n*W +: W] = 32'hFFFF_FFFF;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Responder: on each enable, raise the selected valid k cycles later
  // (k = 0 means never answer).
  initial begin
    cfg_t         c;
    logic [N-1:0] sel;
    forever begin
      @(posedge clk);
      #1;
      if (|sub_ren && cfg_q.size() != 0) begin
        c   = cfg_q.pop_front();
        sel = sub_ren;
        if (c.k > 0) begin
          repeat (c.k) @(posedge clk);
          #1;
          tgt_vd   = sel;
          tgt_data = c.data;
          @(posedge clk);
          #1;
          tgt_vd   = '0;
          tgt_data = '0;
        end
      end
    end
  end

  // Monitor: every response pulse is matched against the scoreboard head.
  initial begin
    exp_t e;
    logic prev_rvd = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_rvd) begin
        check("rd_clear_after_resp", 64'(rsp_rd), 64'd0);
        check("err_clear_after_resp", 64'(rsp_err), 64'd0);
      end
      if (rsp_rvd === 1'b1) begin
        rsp_count++;
        $display("rsp  cyc=%0d data=%08h err=%0b", cyc, rsp_rd, rsp_err);
        if (exp_q.size() == 0) begin
          check("unexpected_rvd", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(rsp_rd), 64'(e.data));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_cycle", 64'(cyc), 64'(e.at));
        end
      end
      prev_rvd = (rsp_rvd === 1'b1);
    end
  end

  // Drive one request (caller is just after a posedge). Returns at the
  // negedge of the following cycle after checking the enable.
  task automatic issue(input logic [A-1:0] addr, input int k, input logic [W-1:0] data,
                       input bit expect_rsp);
    int           idx;
    exp_t         e;
    cfg_t         c;
    logic [N-1:0] oh;
    idx = int'(addr[A-1 -: 4]);
    oh  = '0;
    if (idx < N) begin
      oh   = N'(1) << idx;
      c.k  = k;
      c.data = data;
      cfg_q.push_back(c);
      if (k > 0 && k <= TO) begin
        e.data = data; e.err = 1'b0; e.at = cyc + 2 + k;
      end else begin
        e.data = '0; e.err = 1'b1; e.at = cyc + 2 + TO;
      end
    end else begin
      e.data = '0; e.err = 1'b1; e.at = cyc + 1;
    end
    if (expect_rsp) exp_q.push_back(e);
    $display("req  cyc=%0d addr=%08h slave=%0d delay=%0d", cyc, addr, idx, k);
    req_adrs = addr;
    req_ed   = 1'b1;
    step();
    req_ed   = 1'b0;
    @(negedge clk);
    check("ren_onehot", 64'(sub_ren), 64'(oh));
    if (idx < N) check("sub_adrs", 64'(sub_adrs), 64'(addr));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain_scoreboard", 64'(exp_q.size()), 64'd0);
    step();
    step();
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int saved;

    // Power-on reset
    repeat (3) step();
    check("reset_rvd", 64'(rsp_rvd), 64'd0);
    check("reset_ren", 64'(sub_ren), 64'd0);
    check("reset_rd", 64'(rsp_rd), 64'd0);
    check("reset_err", 64'(rsp_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_adrs", 64'(sub_adrs), 64'd0);
    rst_n = 1'b1;
    step();

    // Minimum latency read from slave 3
    issue(32'h3000_0010, 1, 32'hA5A5_1234, 1'b1);
    drain();

    // Out-of-range select: immediate error, no enable
    issue(32'hB000_0000, 0, 32'h0, 1'b1);
    drain();

    // Timeout, then valid on the last permitted WAIT cycle
    issue(32'h5000_0000, 0, 32'h0, 1'b1);
    drain();
    issue(32'h5000_0000, TO, 32'hCAFE_F00D, 1'b1);
    drain();
    issue(32'h8000_0020, 6, 32'h0BAD_BEEF, 1'b1);
    drain();

    // Other sub-slaves asserting valid must be ignored
    noise_vd = N'((1 << 1) | (1 << 7));
    issue(32'h2000_0000, 2, 32'h0000_0042, 1'b1);
    drain();
    noise_vd = '0;

    // Request while busy is dropped
    issue(32'h4000_0000, 4, 32'h1111_4444, 1'b1);
    step();
    req_adrs = 32'hB000_0000;
    req_ed   = 1'b1;
    @(negedge clk);
    check("busy_in_wait", 64'(busy), 64'd1);
    step();
    req_ed = 1'b0;
    drain();

    // Back-to-back: second request in the IDLE cycle right after RESP
    issue(32'h1000_0004, 1, 32'h0000_0001, 1'b1);
    repeat (3) step();
    issue(32'h8000_0008, 1, 32'h0000_0088, 1'b1);
    drain();

    // Asynchronous reset in the middle of WAIT aborts without a response
    saved = rsp_count;
    issue(32'h5000_0000, 0, 32'h0, 1'b0);
    step();
    step();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_rvd", 64'(rsp_rvd), 64'd0);
    check("async_reset_ren", 64'(sub_ren), 64'd0);
    check("async_reset_adrs", 64'(sub_adrs), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (25) step();
    check("no_rsp_after_reset", 64'(rsp_count), 64'(saved));
    check("post_reset_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
